mul_const_recon: RTL and testbench

MUL_CONST_RECON -- requirements
Module: mul_const_recon

---
 rtl/mul_const_recon.sv | 88 ++++++++
 tb/tb_mul_const_recon.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_const_recon.sv
// mul_const_recon: rebuilds X = C*Q + R from a quotient and remainder using MSB-first Horner shift-add over the bits of C
module mul_const_recon #(
    parameter int QW = 60,
    parameter int RW = 5,
    parameter int XW = 64,
    parameter int C  = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] Q_in,
    input  logic [RW-1:0] R_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] X_out,
    output logic          ovf,
    output logic          err
);
    localparam int CW = $clog2(C + 1);
    localparam int AW = QW + CW;
    localparam int SW = $clog2(CW);
    localparam logic [CW-1:0] CB = CW'(C);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [QW-1:0] q;
    logic [RW-1:0] r;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic [SW-1:0] step;
    logic [XW-1:0] x_nxt;
    logic          ovf_nxt;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // one Horner step: double, add Q when this bit of C is set, fold in R on the last bit
    always_comb acc_nxt = {acc[AW-2:0], 1'b0} + (CB[step] ? AW'(q) : '0) + (step == '0 ? AW'(r) : '0);

    generate
        if (AW > XW) begin : g_wide
            assign x_nxt   = acc_nxt[XW-1:0];
            assign ovf_nxt = |acc_nxt[AW-1:XW];
        end else begin : g_narrow
            assign x_nxt   = XW'(acc_nxt);
            assign ovf_nxt = 1'b0;
        end
    endgenerate

    // control FSM, operand capture, accumulation and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            acc   <= '0;
            step  <= '0;
            X_out <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    q     <= Q_in;
                    r     <= R_in;
                    acc   <= '0;
                    step  <= SW'(CW - 1);
                    state <= ACC;
                end
                ACC: begin
                    acc  <= acc_nxt;
                    step <= step - 1'b1;
                    if (step == '0) begin
                        state <= DONE;
                        X_out <= x_nxt;
                        ovf   <= ovf_nxt;
                        err   <= r >= RW'(C);
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_const_recon.sv
// tb_mul_const_recon: randomized and directed scoreboard bench for mul_const_recon
module tb_mul_const_recon;
    localparam int QW = 60;
    localparam int RW = 5;
    localparam int XW = 64;
    localparam int C  = 23;
    localparam int CW = 5;

    typedef struct {
        logic [XW-1:0] x;
        logic          ovf;
        logic          err;
        int            t;
    } exp_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [QW-1:0] Q_in = '0;
    logic [RW-1:0] R_in = '0;
    logic          out_valid;
    logic          out_ready = 1;
    logic [XW-1:0] X_out;
    logic          ovf;
    logic          err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_valid = 0;
    logic rand_rdy = 0;

    mul_const_recon #(.QW(QW), .RW(RW), .XW(XW), .C(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Q_in(Q_in), .R_in(R_in), .out_valid(out_valid), .out_ready(out_ready),
        .X_out(X_out), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [QW-1:0] q, input logic [RW-1:0] r);
        exp_t e;
        logic [127:0] full;
        full  = 128'(C) * 128'(q) + 128'(r);
        e.x   = full[XW-1:0];
        e.ovf = (full >> XW) != 0;
        e.err = int'(r) >= C;
        e.t   = 0;
        return e;
    endfunction

    function automatic logic [QW-1:0] rand_q();
        logic [63:0] w;
        int sel;
        w = {$urandom(), $urandom()};
        sel = $urandom_range(0, 7);
        if (sel == 0) w = '0;
        if (sel == 1) w = '1;
        if (sel == 2) w = 64'($urandom_range(0, 1000));
        return w[QW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [QW-1:0] q, input logic [RW-1:0] r);
        exp_t e;
        int n = 0;
        logic [63:0] w;
        in_valid = 1;
        Q_in = q;
        R_in = r;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", 64'(in_ready), 64'(1));
        end else begin
            e = model(q, r);
            e.t = cyc + 1;
            sb.push_back(e);
        end
        tick();
        in_valid = 0;
        w = {$urandom(), $urandom()};
        Q_in = w[QW-1:0];
        R_in = RW'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    // monitor: every valid cycle is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (out_valid) begin
            chk("in_ready_in_done", 64'(in_ready), 64'(0));
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out act=valid x=%h exp=no_result", X_out);
            end else begin
                if (!prev_valid) chk("latency", 64'(cyc - sb[0].t), 64'(CW));
                chk("x_out", X_out, sb[0].x);
                chk("ovf", 64'(ovf), 64'(sb[0].ovf));
                chk("err", 64'(err), 64'(sb[0].err));
                if (out_ready) void'(sb.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        logic [63:0] w;
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_x_out", X_out, 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rst_n = 1;
        tick();
        send(60'd43, 5'd11);
        drain();
        chk("direct_1000", X_out, 64'd1000);
        send(60'd0, 5'd0);
        send(60'd1, 5'd22);
        drain();
        chk("direct_45", X_out, 64'd45);
        send('1, 5'd22);
        drain();
        chk("direct_max", X_out, 64'h6FFF_FFFF_FFFF_FFFF);
        chk("direct_max_ovf", 64'(ovf), 64'(1));
        send(60'd5, 5'd23);
        send(60'd5, 5'd31);
        drain();
        chk("direct_146", X_out, 64'd146);
        chk("direct_146_err", 64'(err), 64'(1));
        out_ready = 0;
        send(60'd77, 5'd3);
        repeat (CW) tick();
        chk("stall_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1;
            Q_in = 60'd999;
            R_in = 5'd7;
            tick();
        end
        out_ready = 1;
        tick();
        chk("stall_idle", 64'(in_ready), 64'(1));
        send(60'd999, 5'd7);
        drain();
        send(60'd43, 5'd11);
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("arst_x_out", X_out, 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        void'(sb.pop_back());
        tick();
        rst_n = 1;
        repeat (12) tick();
        send(60'd12345, 5'd6);
        drain();
        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            w = {$urandom(), $urandom()};
            send(rand_q(), w[RW-1:0]);
        end
        rand_rdy = 0;
        #1;
        out_ready = 1;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
